// File: rtl/mul_issue_ctrl_pkg.sv
// Shared types for the RV32M multiply issue controller.
//   mul_funct3_t : funct3 encodings of the MUL family
//   mul_mode_t   : operand signedness (UU / SS / SU)
//   mul_state_t  : issue controller states
package mul_issue_ctrl_pkg;

  typedef enum logic [2:0] {
    F3_MUL    = 3'b000,
    F3_MULH   = 3'b001,
    F3_MULHSU = 3'b010,
    F3_MULHU  = 3'b011
  } mul_funct3_t;

  typedef enum logic [1:0] {
    MODE_UU = 2'd0,
    MODE_SS = 2'd1,
    MODE_SU = 2'd2
  } mul_mode_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_BUSY  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_RESP  = 3'd4
  } mul_state_t;

  // Signedness of (rs1, rs2) for a funct3; illegal encodings fall back to UU.
  function automatic mul_mode_t funct3_mode(input logic [2:0] f3);
    case (f3)
      F3_MULH:   return MODE_SS;
      F3_MULHSU: return MODE_SU;
      default:   return MODE_UU;
    endcase
  endfunction

endpackage

// File: rtl/mul_sign_fix.sv
// Sign handling around the unsigned multiplier.
//   Request side : i_funct3/i_rs1/i_rs2 -> o_mode, o_neg, o_mag_a, o_mag_b
//   Result side  : i_product/i_neg/i_sel_lo -> o_p_fix (corrected 2*XLEN product),
//                  o_word (low word when i_sel_lo, else high word)
module mul_sign_fix
  import mul_issue_ctrl_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [2:0]        i_funct3,
  input  logic [XLEN-1:0]   i_rs1,
  input  logic [XLEN-1:0]   i_rs2,
  output mul_mode_t         o_mode,
  output logic              o_neg,
  output logic [XLEN-1:0]   o_mag_a,
  output logic [XLEN-1:0]   o_mag_b,
  input  logic [2*XLEN-1:0] i_product,
  input  logic              i_neg,
  input  logic              i_sel_lo,
  output logic [2*XLEN-1:0] o_p_fix,
  output logic [XLEN-1:0]   o_word
);

  logic w_neg_a;
  logic w_neg_b;

  assign o_mode  = funct3_mode(i_funct3);
  assign w_neg_a = (o_mode != MODE_UU) & i_rs1[XLEN-1];
  assign w_neg_b = (o_mode == MODE_SS) & i_rs2[XLEN-1];
  assign o_neg   = w_neg_a ^ w_neg_b;

  // Most-negative value negates to itself, which is its correct unsigned magnitude.
  assign o_mag_a = w_neg_a ? -i_rs1 : i_rs1;
  assign o_mag_b = w_neg_b ? -i_rs2 : i_rs2;

  assign o_p_fix = i_neg ? -i_product : i_product;
  assign o_word  = i_sel_lo ? o_p_fix[XLEN-1:0] : o_p_fix[2*XLEN-1:XLEN];

endmodule

// File: rtl/mul_issue_ctrl.sv
// Issue controller for MUL/MULH/MULHSU/MULHU in front of an unsigned multiplier.
//   req_*  : request handshake from execute (valid/ready, funct3, rs1, rs2)
//   resp_* : result handshake back to execute (valid/ready, data)
//   flush  : squash the in-flight request
//   mul_*  : start/ready issue and done/product return to the multiplier
// Illegal funct3, a one-entry product cache and zero operands all answer
// without starting the multiplier.
module mul_issue_ctrl
  import mul_issue_ctrl_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_funct3,
  input  logic [XLEN-1:0]   req_rs1,
  input  logic [XLEN-1:0]   req_rs2,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [XLEN-1:0]   resp_data,
  input  logic              flush,
  output logic              mul_start,
  output logic [XLEN-1:0]   mul_multiplicand,
  output logic [XLEN-1:0]   mul_multiplier,
  input  logic              mul_ready,
  input  logic              mul_done,
  input  logic [2*XLEN-1:0] mul_product
);

  mul_state_t        r_state;
  logic              r_req_ready;
  logic              r_resp_valid;
  logic [XLEN-1:0]   r_resp_data;
  logic              r_mul_start;
  logic [XLEN-1:0]   r_mcand;
  logic [XLEN-1:0]   r_mplier;
  logic              r_neg;
  logic              r_is_mul;
  mul_mode_t         r_mode;
  logic [XLEN-1:0]   r_rs1;
  logic [XLEN-1:0]   r_rs2;
  logic              r_c_valid;
  logic [XLEN-1:0]   r_c_rs1;
  logic [XLEN-1:0]   r_c_rs2;
  mul_mode_t         r_c_mode;
  logic [2*XLEN-1:0] r_c_p;

  mul_mode_t         w_mode;
  logic              w_neg;
  logic [XLEN-1:0]   w_mag_a;
  logic [XLEN-1:0]   w_mag_b;
  logic [2*XLEN-1:0] w_p_fix;
  logic [XLEN-1:0]   w_word;
  logic              w_req_is_mul;
  logic              w_illegal;
  logic              w_zero;
  logic              w_hit;
  logic [XLEN-1:0]   w_hit_word;
  logic              w_accept;

  mul_sign_fix #(.XLEN(XLEN)) u_sign_fix (
    .i_funct3  (req_funct3),
    .i_rs1     (req_rs1),
    .i_rs2     (req_rs2),
    .o_mode    (w_mode),
    .o_neg     (w_neg),
    .o_mag_a   (w_mag_a),
    .o_mag_b   (w_mag_b),
    .i_product (mul_product),
    .i_neg     (r_neg),
    .i_sel_lo  (r_is_mul),
    .o_p_fix   (w_p_fix),
    .o_word    (w_word)
  );

  assign w_req_is_mul = (req_funct3 == F3_MUL);
  assign w_illegal    = req_funct3[2];
  assign w_zero       = (req_rs1 == '0) || (req_rs2 == '0);
  // Low word is signedness-independent, so MUL may reuse a product of any mode.
  assign w_hit        = r_c_valid && (req_rs1 == r_c_rs1) && (req_rs2 == r_c_rs2) &&
                        (w_req_is_mul || (w_mode == r_c_mode));
  assign w_hit_word   = w_req_is_mul ? r_c_p[XLEN-1:0] : r_c_p[2*XLEN-1:XLEN];
  assign w_accept     = req_valid && (r_state == ST_IDLE) && !flush;

  // Controller state, handshakes and product cache.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_data  <= '0;
      r_mul_start  <= 1'b0;
      r_mcand      <= '0;
      r_mplier     <= '0;
      r_neg        <= 1'b0;
      r_is_mul     <= 1'b0;
      r_mode       <= MODE_UU;
      r_rs1        <= '0;
      r_rs2        <= '0;
      r_c_valid    <= 1'b0;
      r_c_rs1      <= '0;
      r_c_rs2      <= '0;
      r_c_mode     <= MODE_UU;
      r_c_p        <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_req_ready <= 1'b0;
            r_neg       <= w_neg;
            r_is_mul    <= w_req_is_mul;
            r_mode      <= w_mode;
            r_rs1       <= req_rs1;
            r_rs2       <= req_rs2;
            if (w_illegal) begin
              r_state      <= ST_RESP;
              r_resp_valid <= 1'b1;
              r_resp_data  <= '0;
            end else if (w_hit) begin
              r_state      <= ST_RESP;
              r_resp_valid <= 1'b1;
              r_resp_data  <= w_hit_word;
            end else if (w_zero) begin
              r_state      <= ST_RESP;
              r_resp_valid <= 1'b1;
              r_resp_data  <= '0;
            end else begin
              r_state     <= ST_START;
              r_mul_start <= 1'b1;
              r_mcand     <= w_mag_a;
              r_mplier    <= w_mag_b;
            end
          end
        end
        ST_START: begin
          // A handshake in the flush cycle leaves a multiply in flight to drain.
          if (flush) begin
            r_mul_start <= 1'b0;
            r_state     <= mul_ready ? ST_DRAIN : ST_IDLE;
            r_req_ready <= !mul_ready;
          end else if (mul_ready) begin
            r_mul_start <= 1'b0;
            r_state     <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (flush) begin
            r_state <= ST_DRAIN;
          end else if (mul_done) begin
            r_state      <= ST_RESP;
            r_resp_valid <= 1'b1;
            r_resp_data  <= w_word;
            r_c_valid    <= 1'b1;
            r_c_rs1      <= r_rs1;
            r_c_rs2      <= r_rs2;
            r_c_mode     <= r_mode;
            r_c_p        <= w_p_fix;
          end
        end
        ST_DRAIN: begin
          if (mul_done) begin
            r_state     <= ST_IDLE;
            r_req_ready <= 1'b1;
          end
        end
        ST_RESP: begin
          if (resp_ready || flush) begin
            r_state      <= ST_IDLE;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_req_ready <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready        = r_req_ready;
  assign resp_valid       = r_resp_valid;
  assign resp_data        = r_resp_data;
  assign mul_start        = r_mul_start;
  assign mul_multiplicand = r_mcand;
  assign mul_multiplier   = r_mplier;

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Bench for mul_issue_ctrl: behavioural multiplier with random latency and
// ready stalls, arithmetic reference model, directed corner cases, random ops.
module tb_mul_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_funct3;
  logic [31:0] req_rs1;
  logic [31:0] req_rs2;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        flush;
  logic        mul_start;
  logic [31:0] mul_multiplicand;
  logic [31:0] mul_multiplier;
  logic        mul_ready;
  logic        mul_done;
  logic [63:0] mul_product;

  mul_issue_ctrl #(.XLEN(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_funct3       (req_funct3),
    .req_rs1          (req_rs1),
    .req_rs2          (req_rs2),
    .resp_valid       (resp_valid),
    .resp_ready       (resp_ready),
    .resp_data        (resp_data),
    .flush            (flush),
    .mul_start        (mul_start),
    .mul_multiplicand (mul_multiplicand),
    .mul_multiplier   (mul_multiplier),
    .mul_ready        (mul_ready),
    .mul_done         (mul_done),
    .mul_product      (mul_product)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_bad    = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // ---------------- behavioural unsigned multiplier ----------------
  int unsigned n_starts = 0;
  bit          force_stall = 1'b0;
  bit          rand_stall  = 1'b0;
  int          lat_min = 1;
  int          lat_max = 6;
  logic        m_busy;
  int          m_cnt;
  logic [31:0] m_a, m_b;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy      <= 1'b0;
      m_cnt       <= 0;
      m_a         <= '0;
      m_b         <= '0;
      mul_ready   <= 1'b1;
      mul_done    <= 1'b0;
      mul_product <= '0;
    end else begin
      mul_done    <= 1'b0;
      mul_product <= {$urandom, $urandom};
      if (m_busy) begin
        if (m_cnt == 0) begin
          mul_done    <= 1'b1;
          mul_product <= {32'd0, m_a} * {32'd0, m_b};
          m_busy      <= 1'b0;
          mul_ready   <= !force_stall;
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end else if (mul_start && mul_ready) begin
        m_a       <= mul_multiplicand;
        m_b       <= mul_multiplier;
        m_busy    <= 1'b1;
        m_cnt     <= int'($urandom_range(lat_max, lat_min)) - 1;
        mul_ready <= 1'b0;
        n_starts  <= n_starts + 1;
      end else begin
        mul_ready <= !force_stall && (!rand_stall || ($urandom_range(0, 3) != 0));
      end
    end
  end

  // ---------------- reference model ----------------
  bit          mc_valid = 1'b0;
  logic [31:0] mc_a, mc_b;
  int          mc_mode;

  function automatic int mode_of(input logic [2:0] f3);
    if (f3 == 3'd1) return 1;
    if (f3 == 3'd2) return 2;
    return 0;
  endfunction

  function automatic logic [31:0] ref_mul(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, ub;
    logic [63:0] p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ub = {32'd0, b};
    case (f3)
      3'd0: p = {32'd0, a} * {32'd0, b};
      3'd1: p = sa * sb;
      3'd2: p = sa * ub;
      3'd3: p = {32'd0, a} * {32'd0, b};
      default: return 32'd0;
    endcase
    return (f3 == 3'd0) ? p[31:0] : p[63:32];
  endfunction

  task automatic wait_req_ready();
    int cyc = 0;
    while (!req_ready && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    check_eq("req_ready_wait", req_ready, 1);
  endtask

  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input int hold);
    logic [31:0] want;
    bit          issue;
    int unsigned s0;
    int          cyc;
    bit          prev_done;
    want  = ref_mul(f3, a, b);
    issue = !f3[2] && (a != 0) && (b != 0) &&
            !(mc_valid && a == mc_a && b == mc_b && (f3 == 3'd0 || mode_of(f3) == mc_mode));
    wait_req_ready();
    s0 = n_starts;
    req_valid = 1'b1; req_funct3 = f3; req_rs1 = a; req_rs2 = b;
    @(posedge clk); #1;
    req_valid = 1'b0;
    cyc = 1;
    prev_done = 1'b0;
    if (!issue) check_eq("no_start", mul_start, 0);
    while (!resp_valid && cyc < 300) begin
      prev_done = mul_done;
      @(posedge clk); #1;
      cyc++;
    end
    check_eq("resp_valid", resp_valid, 1);
    check_eq("resp_data", resp_data, want);
    if (issue) check_eq("done_to_valid", prev_done, 1);
    else       check_eq("fast_latency", cyc, 1);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check_eq("hold_valid", resp_valid, 1);
      check_eq("hold_data", resp_data, want);
      check_eq("hold_req_ready", req_ready, 0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check_eq("consumed_valid", resp_valid, 0);
    check_eq("consumed_req_ready", req_ready, 1);
    check_eq("start_count", n_starts - s0, issue);
    if (issue) begin
      mc_valid = 1'b1; mc_a = a; mc_b = b; mc_mode = mode_of(f3);
    end
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int unsigned s1;
    int          cyc;
    bit          acc, saw_done, early;
    logic [31:0] ra, rb;
    logic [2:0]  rf;

    rst = 1'b0; req_valid = 1'b0; req_funct3 = '0; req_rs1 = '0; req_rs2 = '0;
    resp_ready = 1'b0; flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_req_ready", req_ready, 1);
    check_eq("rst_resp_valid", resp_valid, 0);
    check_eq("rst_resp_data", resp_data, 0);
    check_eq("rst_mul_start", mul_start, 0);
    check_eq("rst_mcand", mul_multiplicand, 0);
    check_eq("rst_mplier", mul_multiplier, 0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    // directed arithmetic and shortcut cases
    run_op(3'd0, 32'd7, 32'd6, 0);
    run_op(3'd1, 32'hFFFF_FFFF, 32'h0000_0002, 0);
    run_op(3'd0, 32'hFFFF_FFFF, 32'h0000_0002, 0);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 0);
    run_op(3'd0, 32'h0000_0000, 32'h1234_5678, 0);
    run_op(3'b100, 32'd5, 32'd7, 0);
    run_op(3'd1, 32'h0123_4567, 32'h89AB_CDEF, 5);

    // flush in START before the multiplier is ready
    force_stall = 1'b1;
    @(posedge clk); #1;
    wait_req_ready();
    s1 = n_starts;
    req_valid = 1'b1; req_funct3 = 3'd0; req_rs1 = 32'd11; req_rs2 = 32'd13;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check_eq("start_raised", mul_start, 1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check_eq("start_flush_start", mul_start, 0);
    check_eq("start_flush_ready", req_ready, 1);
    check_eq("start_flush_valid", resp_valid, 0);
    check_eq("start_flush_count", n_starts - s1, 0);
    force_stall = 1'b0;
    @(posedge clk); #1;

    // flush in BUSY, then a new op that must wait for the drained product
    lat_min = 4; lat_max = 4;
    wait_req_ready();
    s1 = n_starts;
    req_valid = 1'b1; req_funct3 = 3'd0; req_rs1 = 32'd9; req_rs2 = 32'd9;
    @(posedge clk); #1;
    req_valid = 1'b0;
    cyc = 0;
    while (!m_busy && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check_eq("busy_reached", m_busy, 1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    req_valid = 1'b1; req_funct3 = 3'd0; req_rs1 = 32'd3; req_rs2 = 32'd5;
    saw_done = 1'b0; early = 1'b0; cyc = 0;
    while (!resp_valid && cyc < 100) begin
      acc = req_valid && req_ready;
      if (mul_done) saw_done = 1'b1;
      if (mul_start && !saw_done) early = 1'b1;
      @(posedge clk); #1;
      cyc++;
      if (acc) req_valid = 1'b0;
    end
    req_valid = 1'b0;
    check_eq("drain_resp_valid", resp_valid, 1);
    check_eq("drain_resp_data", resp_data, 32'h0000_000F);
    check_eq("drain_early_start", early, 0);
    check_eq("drain_start_count", n_starts - s1, 2);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    mc_valid = 1'b1; mc_a = 32'd3; mc_b = 32'd5; mc_mode = 0;
    lat_min = 1; lat_max = 6;
    run_op(3'd0, 32'd9, 32'd9, 0);

    // flush drops a pending response
    wait_req_ready();
    req_valid = 1'b1; req_funct3 = 3'd0; req_rs1 = 32'd0; req_rs2 = 32'd5;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check_eq("resp_flush_pre", resp_valid, 1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check_eq("resp_flush_valid", resp_valid, 0);
    check_eq("resp_flush_ready", req_ready, 1);

    // flush with a request in IDLE: nothing accepted
    req_valid = 1'b1; flush = 1'b1; req_funct3 = 3'd0; req_rs1 = 32'd0; req_rs2 = 32'd1;
    @(posedge clk); #1;
    req_valid = 1'b0; flush = 1'b0;
    check_eq("idle_flush_valid", resp_valid, 0);
    check_eq("idle_flush_ready", req_ready, 1);

    // random traffic
    rand_stall = 1'b1;
    ra = 32'd1; rb = 32'd1;
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 2) != 0) begin
        ra = pick_operand();
        rb = pick_operand();
      end
      rf = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      run_op(rf, ra, rb, int'($urandom_range(0, 2)));
    end
    rand_stall = 1'b0;

    // asynchronous reset in BUSY
    run_op(3'd0, 32'd3, 32'd5, 0);
    lat_min = 20; lat_max = 20;
    wait_req_ready();
    req_valid = 1'b1; req_funct3 = 3'd1; req_rs1 = 32'h0000_1234; req_rs2 = 32'h0000_5678;
    @(posedge clk); #1;
    req_valid = 1'b0;
    cyc = 0;
    while (!m_busy && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check_eq("rst_busy_reached", m_busy, 1);
    #2 rst = 1'b0;
    #1;
    check_eq("arst_req_ready", req_ready, 1);
    check_eq("arst_resp_valid", resp_valid, 0);
    check_eq("arst_resp_data", resp_data, 0);
    check_eq("arst_mul_start", mul_start, 0);
    check_eq("arst_mcand", mul_multiplicand, 0);
    check_eq("arst_mplier", mul_multiplier, 0);
    mc_valid = 1'b0;
    lat_min = 1; lat_max = 6;
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    run_op(3'd0, 32'd3, 32'd5, 0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/mul_issue_ctrl.md
Name: mul_issue_ctrl

Overview:
- Front-end controller for the RV32M MUL/MULH/MULHSU/MULHU instructions.
- Sits between the execute stage and the unsigned shift-add multiplier (multiplicand/multiplier/start/ready/product/done handshake).
- Converts signed operands to magnitudes, issues the unsigned multiply, sign-corrects the 64-bit product, selects the high or low word, and returns the result with a valid/ready handshake.
- Also provides a zero-operand shortcut and a one-entry product cache, so a MULH→MUL pair on identical operands costs one multiply.

Parameters:
XLEN, 32, operand width; product width is 2*XLEN.

Ports:
clk  in  1  clock
rst  in  1  reset; one clock; reset is asynchronous and active-low
req_valid  in  1  request present
req_ready  out  1  unit can accept request
req_funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
req_rs1  in  XLEN  operand a
req_rs2  in  XLEN  operand b
resp_valid  out  1  result available
resp_ready  in  1  consumer takes result
resp_data  out  XLEN  result word
flush  in  1  squash in-flight request
mul_start  out  1  start to multiplier
mul_multiplicand  out  XLEN  |a|
mul_multiplier  out  XLEN  |b|
mul_ready  in  1  multiplier idle
mul_done  in  1  one-cycle completion pulse
mul_product  in  2*XLEN  unsigned product, valid when mul_done=1

Behaviour:
- Reset (rst=0, async) forces:
  - state=IDLE; resp_valid=0; resp_data=0; mul_start=0; mul_multiplicand=0; mul_multiplier=0; cache_valid=0.
  - req_ready=1 (req_ready is 1 only in IDLE).
- Accept on req_valid & req_ready; operands, funct3 and mode are latched.
- Mode, per operand signedness:
  - MUL/MULHU: UU.
  - MULH: SS.
  - MULHSU: SU.
  - neg = (signed_a & a[31]) ^ (signed_b & b[31]).
  - Magnitude = two's-complement negate when the operand is signed and negative. 0x80000000 maps to unsigned 0x80000000 (no overflow special case).
- Sign correction: P_fix = neg ? (~P + 1) : P, computed over 64 bits.
- Result select: resp_data = MUL ? P_fix[31:0] : P_fix[63:32].
- funct3[2]=1 is illegal: accepted; RESP next cycle with resp_data=0; multiplier not started.
- Zero shortcut: rs1==0 or rs2==0 → RESP next cycle, resp_data=0; mul_start never asserted; cache not updated.
- Cache hit (cache_valid, rs1==c_rs1, rs2==c_rs2, and (MUL or mode==c_mode)):
  - RESP next cycle from the cached P_fix; no multiply.
  - Hit takes priority below illegal, above the zero shortcut.
- FSM:
  - IDLE→START on an accepted miss.
  - START: mul_start=1 and operands driven; go to BUSY when mul_ready=1 in that cycle. mul_start stays high until mul_ready is seen.
  - BUSY: on mul_done, latch P_fix, update the cache (c_rs1, c_rs2, c_mode, c_P, valid), go to RESP. resp_valid rises the cycle after mul_done.
  - RESP: resp_valid=1 and resp_data held stable until resp_ready; then →IDLE. req_ready is 0 in RESP, so there is no back-to-back accept in the same cycle.
  - DRAIN: wait for mul_done, discard the product, no cache update, →IDLE.
- Flush:
  - IDLE: no effect.
  - START before handshake: →IDLE; mul_start drops the next cycle.
  - START with mul_ready=1 in the same cycle: →DRAIN.
  - BUSY: →DRAIN.
  - RESP: drop the response; resp_valid=0 the next cycle.
  - Flush has priority over mul_done in the same cycle.
  - Flush together with req_valid in IDLE: the request is not accepted.
- Simultaneous resp_ready and flush in RESP: the response counts as consumed; next state IDLE.

Decomposition:
- Shared package (types): mul_funct3_t enum, mul_mode_t enum (UU/SS/SU), mul_state_t enum (IDLE/START/BUSY/DRAIN/RESP).
- Sub-module mul_sign_fix (combinational): magnitude and neg computation on the request side; product negation and high/low select on the result side.

Test Plan:
- MUL 7*6 → mul_start asserted once; resp_data=0x0000002A; resp_valid rises the cycle after mul_done.
- MULH 0xFFFFFFFF*0x00000002 → 0xFFFFFFFF. Then MUL on the same operands → cache hit: 0xFFFFFFFE one cycle after accept, no mul_start.
- MULHU 0xFFFFFFFF*0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0x80000000*0xFFFFFFFF → 0x80000000. MULH 0x80000000*0x80000000 → 0x40000000.
- MUL 0x00000000*0x12345678 → resp_data=0 one cycle after accept; mul_start stays 0; funct3=100 → resp_data=0.
- Hold resp_ready=0 for 5 cycles → resp_valid and resp_data stable, req_ready=0.
- Flush in BUSY, then a new MUL 3*5:
  - No response for the flushed op.
  - The new op is not started until the drained mul_done.
  - Result 0x0000000F.
- Assert rst=0 mid-BUSY → outputs reach reset values without a clock edge.
